issue_scoreboard: RTL and testbench

Dual-issue scoreboard and issue controller for the two-pipe (master/slave) integer datapath. It tracks architectural registers with an in-flight write and decides, per cycle, whether the decoded pair issues fully, master-only, or not at all. It also provides a drain/synchronise handshake for serialising instructions and reports the in-flight count. It sits between decode and the register-file read stage; its clear inputs come from the two write-back ports.

---
 rtl/issue_scoreboard.sv | 113 +++++++++++
 tb/tb_issue_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard for the master/slave integer pipes. It tracks in-flight register
// writes, decides each cycle how much of the decoded pair issues, and drains on request.
module issue_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       m_valid,
    input  logic [4:0] m_rs,
    input  logic [4:0] m_rt,
    input  logic       m_wen,
    input  logic [4:0] m_wa,
    input  logic       s_valid,
    input  logic [4:0] s_rs,
    input  logic [4:0] s_rt,
    input  logic       s_wen,
    input  logic [4:0] s_wa,
    input  logic       s_pair_ok,
    input  logic       wb1_en,
    input  logic [4:0] wb1_wa,
    input  logic       wb2_en,
    input  logic [4:0] wb2_wa,
    input  logic       sync_req,
    output logic       m_issue,
    output logic       s_issue,
    output logic       sync_ack,
    output logic [5:0] pending_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

    state_t      state;
    logic [31:0] pending;
    logic [31:0] wbclr;
    logic [31:0] eff;
    logic [31:0] set_vec;
    logic [31:0] pending_next;
    logic        m_haz;
    logic        s_haz;
    logic        pair_dep;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Write-back clears count as ready this cycle thanks to register-file write-through.
    always_comb begin
        wbclr = '0;
        if (wb1_en) wbclr[wb1_wa] = 1'b1;
        if (wb2_en) wbclr[wb2_wa] = 1'b1;
    end

    assign eff = pending & ~wbclr;

    assign m_haz    = eff[m_rs] | eff[m_rt] | (m_wen & eff[m_wa]);
    assign pair_dep = m_wen & (m_wa != 5'd0) &
                      ((s_rs == m_wa) | (s_rt == m_wa) | (s_wen & (s_wa == m_wa)));
    assign s_haz    = eff[s_rs] | eff[s_rt] | (s_wen & eff[s_wa]) | pair_dep;

    assign m_issue = m_valid & (state == RUN) & ~sync_req & ~flush & ~m_haz;
    assign s_issue = m_issue & s_valid & s_pair_ok & ~s_haz;

    always_comb begin
        set_vec = '0;
        if (m_issue && m_wen) set_vec[m_wa] = 1'b1;
        if (s_issue && s_wen) set_vec[s_wa] = 1'b1;
        if (flush) begin
            pending_next = '0;
        end else begin
            pending_next = eff | set_vec;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pending     <= '0;
            sync_ack    <= 1'b0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_next;
            pending_cnt <= popcount32(pending_next);
            sync_ack    <= 1'b0;
            if (flush) begin
                state <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (sync_req) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (eff == 32'd0) begin
                            state    <= ACK;
                            sync_ack <= 1'b1;
                        end
                    end
                    ACK: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hand-computed issue decisions, counts and sync handshake.
module tb_issue_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       m_valid, m_wen, s_valid, s_wen, s_pair_ok;
    logic [4:0] m_rs, m_rt, m_wa, s_rs, s_rt, s_wa;
    logic       wb1_en, wb2_en;
    logic [4:0] wb1_wa, wb2_wa;
    logic       sync_req;
    logic       m_issue, s_issue, sync_ack;
    logic [5:0] pending_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    issue_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .m_valid(m_valid), .m_rs(m_rs), .m_rt(m_rt), .m_wen(m_wen), .m_wa(m_wa),
        .s_valid(s_valid), .s_rs(s_rs), .s_rt(s_rt), .s_wen(s_wen), .s_wa(s_wa),
        .s_pair_ok(s_pair_ok),
        .wb1_en(wb1_en), .wb1_wa(wb1_wa), .wb2_en(wb2_en), .wb2_wa(wb2_wa),
        .sync_req(sync_req),
        .m_issue(m_issue), .s_issue(s_issue), .sync_ack(sync_ack), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush = 0; sync_req = 0;
        m_valid = 0; m_rs = 0; m_rt = 0; m_wen = 0; m_wa = 0;
        s_valid = 0; s_rs = 0; s_rt = 0; s_wen = 0; s_wa = 0; s_pair_ok = 0;
        wb1_en = 0; wb1_wa = 0; wb2_en = 0; wb2_wa = 0;
    endtask

    // Advance past the next rising edge and return inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mst(input logic [4:0] rs, input logic [4:0] rt,
                       input logic wen, input logic [4:0] wa);
        m_valid = 1; m_rs = rs; m_rt = rt; m_wen = wen; m_wa = wa;
    endtask

    task automatic slv(input logic [4:0] rs, input logic [4:0] rt,
                       input logic wen, input logic [4:0] wa, input logic ok);
        s_valid = 1; s_rs = rs; s_rt = rt; s_wen = wen; s_wa = wa; s_pair_ok = ok;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(pending_cnt), 0);
        chk("rst_ack", 32'(sync_ack), 0);
        rst = 1'b0;

        // Basic pairing right after reset release
        mst(0, 0, 1, 5); slv(0, 0, 1, 6, 1); #1;
        chk("pair_m", 32'(m_issue), 1);
        chk("pair_s", 32'(s_issue), 1);
        next_cycle();
        mst(5, 0, 0, 0); #1;
        chk("pair_cnt", 32'(pending_cnt), 2);
        chk("raw_r5_m", 32'(m_issue), 0);
        next_cycle();
        mst(0, 0, 0, 0); slv(6, 0, 0, 0, 1); #1;
        chk("raw_r6_m", 32'(m_issue), 1);
        chk("raw_r6_s", 32'(s_issue), 0);
        next_cycle();
        wb1_en = 1; wb1_wa = 5; wb2_en = 1; wb2_wa = 6;
        mst(5, 0, 0, 0); slv(0, 6, 0, 0, 1); #1;
        chk("byp_m", 32'(m_issue), 1);
        chk("byp_s", 32'(s_issue), 1);
        chk("byp_cnt", 32'(pending_cnt), 2);

        // Intra-pair RAW
        next_cycle();
        mst(0, 0, 1, 3); slv(3, 0, 0, 0, 1); #1;
        chk("ip_cnt0", 32'(pending_cnt), 0);
        chk("ip_m", 32'(m_issue), 1);
        chk("ip_s", 32'(s_issue), 0);
        next_cycle();
        mst(0, 0, 1, 7); slv(0, 0, 1, 8, 0); #1;
        chk("ip_cnt1", 32'(pending_cnt), 1);
        chk("nopair_m", 32'(m_issue), 1);
        chk("nopair_s", 32'(s_issue), 0);

        // Cross-cycle RAW on r7, then write-back bypass
        next_cycle();
        mst(7, 0, 0, 0); #1;
        chk("r7_cnt", 32'(pending_cnt), 2);
        chk("r7_blk", 32'(m_issue), 0);
        next_cycle();
        mst(0, 7, 0, 0); #1;
        chk("r7_blk2", 32'(m_issue), 0);
        next_cycle();
        wb1_en = 1; wb1_wa = 7; wb2_en = 1; wb2_wa = 3;
        mst(7, 0, 0, 0); #1;
        chk("r7_byp", 32'(m_issue), 1);

        // r0 writes are ignored
        next_cycle();
        mst(0, 0, 1, 0); slv(0, 0, 1, 0, 1); #1;
        chk("r0_cnt_a", 32'(pending_cnt), 0);
        chk("r0_m", 32'(m_issue), 1);
        chk("r0_s", 32'(s_issue), 1);
        next_cycle();
        mst(0, 0, 1, 9); #1;
        chk("r0_cnt_b", 32'(pending_cnt), 0);
        chk("r9_m", 32'(m_issue), 1);

        // Set wins over clear on r9
        next_cycle();
        wb2_en = 1; wb2_wa = 9;
        mst(0, 0, 1, 9); #1;
        chk("r9_cnt", 32'(pending_cnt), 1);
        chk("r9_re", 32'(m_issue), 1);
        next_cycle();
        mst(0, 0, 1, 9); #1;
        chk("r9_set_cnt", 32'(pending_cnt), 1);
        chk("r9_waw", 32'(m_issue), 0);
        next_cycle();
        wb1_en = 1; wb1_wa = 9; #1;
        next_cycle();
        mst(0, 0, 1, 4); #1;
        chk("sync_pre_cnt", 32'(pending_cnt), 0);
        chk("sync_pre_m", 32'(m_issue), 1);

        // Sync drain with r4 pending
        next_cycle();
        sync_req = 1; mst(0, 0, 0, 0); #1;
        chk("sreq_cnt", 32'(pending_cnt), 1);
        chk("sreq_m", 32'(m_issue), 0);
        next_cycle();
        sync_req = 1; mst(0, 0, 0, 0); #1;
        chk("drain_m", 32'(m_issue), 0);
        chk("drain_ack", 32'(sync_ack), 0);
        next_cycle();
        sync_req = 1; wb1_en = 1; wb1_wa = 4; #1;
        chk("drainN_ack", 32'(sync_ack), 0);
        next_cycle();
        mst(0, 0, 0, 0); #1;
        chk("ack_pulse", 32'(sync_ack), 1);
        chk("ack_m", 32'(m_issue), 0);
        chk("ack_cnt", 32'(pending_cnt), 0);
        next_cycle();
        mst(0, 0, 1, 4); #1;
        chk("ack_end", 32'(sync_ack), 0);
        chk("run_m", 32'(m_issue), 1);

        // Flush one cycle before the releasing write-back
        next_cycle();
        sync_req = 1; #1;
        chk("fl_cnt1", 32'(pending_cnt), 1);
        next_cycle();
        sync_req = 1; flush = 1; mst(0, 0, 0, 0); #1;
        chk("fl_m", 32'(m_issue), 0);
        next_cycle();
        wb1_en = 1; wb1_wa = 4; mst(0, 0, 0, 0); #1;
        chk("fl_ack", 32'(sync_ack), 0);
        chk("fl_cnt0", 32'(pending_cnt), 0);
        chk("fl_run", 32'(m_issue), 1);
        next_cycle();
        flush = 1; mst(0, 0, 1, 10); #1;
        chk("fl_ack2", 32'(sync_ack), 0);
        chk("fl_blk", 32'(m_issue), 0);
        next_cycle();
        mst(0, 0, 1, 11); slv(0, 0, 1, 12, 1); #1;
        chk("fl_cnt2", 32'(pending_cnt), 0);
        chk("ar_s", 32'(s_issue), 1);

        // Async reset in the middle of a drain
        next_cycle();
        mst(0, 0, 1, 13); #1;
        next_cycle();
        sync_req = 1; #1;
        chk("ar_cnt3", 32'(pending_cnt), 3);
        next_cycle();
        sync_req = 1; #1;
        chk("ar_drain_cnt", 32'(pending_cnt), 3);
        rst = 1'b1; #1;
        chk("ar_cnt0", 32'(pending_cnt), 0);
        chk("ar_ack0", 32'(sync_ack), 0);
        #1 rst = 1'b0;
        idle();
        mst(11, 0, 0, 0); #1;
        chk("ar_run_m", 32'(m_issue), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
